// File: rtl/fpmul_pkg.sv
// Shared types and IEEE-754 single-precision constants for the shared
// floating-point multiplier arbiter.
package fpmul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int EXP_W    = 8;
  localparam int FRAC_W   = 23;
  localparam int EXP_BIAS = 127;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [31:0] PINF = 32'h7F80_0000;
  localparam logic [31:0] NINF = 32'hFF80_0000;

endpackage

// File: rtl/fpmul_mulunit.sv
// Combinational single-precision multiplier: round-to-nearest-even,
// denormal inputs and underflow flush to signed zero, overflow goes to infinity.
module fpmul_mulunit
  import fpmul_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_p
);

  localparam int MANT_W = FRAC_W + 1;
  localparam int PROD_W = 2 * MANT_W;
  localparam int SEXP_W = EXP_W + 2;
  localparam logic signed [SEXP_W-1:0] SEXP_ZERO = '0;
  localparam logic signed [SEXP_W-1:0] SEXP_INF  = {2'b00, {EXP_W{1'b1}}};
  localparam logic signed [SEXP_W-1:0] SEXP_BIAS = SEXP_W'(EXP_BIAS);

  logic                     w_sign;
  logic [PROD_W-1:0]        w_prod;
  logic signed [SEXP_W-1:0] w_ea, w_eb, w_exp_raw, w_exp_norm, w_exp_fin;
  logic [FRAC_W-1:0]        w_mant;
  logic                     w_guard, w_sticky;
  logic [MANT_W-1:0]        w_rnd;

  function automatic logic [MANT_W-1:0] round_rne(input logic [FRAC_W-1:0] mant,
                                                  input logic guard,
                                                  input logic sticky);
    round_rne = {1'b0, mant} + MANT_W'(guard && (sticky || mant[0]));
  endfunction

  assign w_sign = i_a[31] ^ i_b[31];
  assign w_ea   = {2'b00, i_a[FRAC_W +: EXP_W]};
  assign w_eb   = {2'b00, i_b[FRAC_W +: EXP_W]};
  assign w_prod = PROD_W'({1'b1, i_a[FRAC_W-1:0]}) * PROD_W'({1'b1, i_b[FRAC_W-1:0]});

  always_comb begin
    w_exp_raw = w_ea + w_eb - SEXP_BIAS;
    // Product of two [1,2) mantissas lies in [1,4); renormalise when >= 2
    if (w_prod[PROD_W-1]) begin
      w_mant   = w_prod[PROD_W-2 -: FRAC_W];
      w_guard  = w_prod[PROD_W-2-FRAC_W];
      w_sticky = |w_prod[PROD_W-3-FRAC_W:0];
    end else begin
      w_mant   = w_prod[PROD_W-3 -: FRAC_W];
      w_guard  = w_prod[PROD_W-3-FRAC_W];
      w_sticky = |w_prod[PROD_W-4-FRAC_W:0];
    end
    w_exp_norm = w_exp_raw + {{(SEXP_W-1){1'b0}}, w_prod[PROD_W-1]};
    w_rnd      = round_rne(w_mant, w_guard, w_sticky);
    w_exp_fin  = w_exp_norm + {{(SEXP_W-1){1'b0}}, w_rnd[MANT_W-1]};

    if (w_ea == SEXP_ZERO || w_eb == SEXP_ZERO || w_exp_fin <= SEXP_ZERO) begin
      o_p = {w_sign, 31'd0};
    end else if (w_exp_fin >= SEXP_INF) begin
      o_p = {w_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    end else begin
      o_p = {w_sign, w_exp_fin[EXP_W-1:0], w_rnd[FRAC_W-1:0]};
    end
  end

endmodule

// File: rtl/fpmul_rr_arb.sv
// Two-way round-robin arbiter: a lone requester wins, and on contention the
// requester that was not granted last wins.
module fpmul_rr_arb (
  input  logic       i_valid0,
  input  logic       i_valid1,
  input  logic       i_last,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = 2'b00;
    if (i_valid0 && i_valid1) begin
      o_grant = i_last ? 2'b01 : 2'b10;
    end else if (i_valid0) begin
      o_grant = 2'b01;
    end else if (i_valid1) begin
      o_grant = 2'b10;
    end
  end

endmodule

// File: rtl/fpmul_arbiter.sv
// Two requesters share one FP multiplier, one operation in flight at a time.
// Define FPMUL_SPECIAL_EN to add IEEE zero/Inf/NaN special-case decoding.
module fpmul_arbiter
  import fpmul_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [31:0]      rsp0_data,
  output logic [TAG_W-1:0] rsp0_tag,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [31:0]      rsp1_data,
  output logic [TAG_W-1:0] rsp1_tag,
  output logic             busy,
  output logic [15:0]      ops_cnt
);

  state_t           r_state, w_state_nxt;
  logic             r_last;
  logic [1:0]       w_grant;
  logic             w_req_hs, w_rsp_hs;
  logic             r_owner;
  logic [31:0]      r_a, r_b;
  logic [TAG_W-1:0] r_tag;
  logic [1:0]       r_rsp_valid;
  logic [31:0]      r_rsp_data;
  logic [TAG_W-1:0] r_rsp_tag;
  logic [15:0]      r_ops_cnt;
  logic [31:0]      w_mul, w_res;

  fpmul_rr_arb u_arb (
    .i_valid0 (req0_valid),
    .i_valid1 (req1_valid),
    .i_last   (r_last),
    .o_grant  (w_grant)
  );

  fpmul_mulunit u_mul (
    .i_a (r_a),
    .i_b (r_b),
    .o_p (w_mul)
  );

  assign req0_ready = rst_n && (r_state == IDLE) && w_grant[0];
  assign req1_ready = rst_n && (r_state == IDLE) && w_grant[1];
  assign w_req_hs   = req0_ready || req1_ready;
  assign w_rsp_hs   = (r_state == RESP) &&
                      (r_owner ? (r_rsp_valid[1] && rsp1_ready) : (r_rsp_valid[0] && rsp0_ready));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_req_hs) w_state_nxt = EXEC;
      EXEC:    w_state_nxt = RESP;
      RESP:    if (w_rsp_hs) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

`ifdef FPMUL_SPECIAL_EN
  logic w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan, w_sign;

  assign w_a_zero = ~|r_a[30:0];
  assign w_b_zero = ~|r_b[30:0];
  assign w_a_inf  = (&r_a[FRAC_W +: EXP_W]) && ~|r_a[FRAC_W-1:0];
  assign w_b_inf  = (&r_b[FRAC_W +: EXP_W]) && ~|r_b[FRAC_W-1:0];
  assign w_a_nan  = (&r_a[FRAC_W +: EXP_W]) &&  |r_a[FRAC_W-1:0];
  assign w_b_nan  = (&r_b[FRAC_W +: EXP_W]) &&  |r_b[FRAC_W-1:0];
  assign w_sign   = r_a[31] ^ r_b[31];

  always_comb begin
    w_res = w_mul;
    if (w_a_nan || w_b_nan || (w_a_zero && w_b_inf) || (w_a_inf && w_b_zero)) begin
      w_res = QNAN;
    end else if (w_a_inf || w_b_inf) begin
      w_res = w_sign ? NINF : PINF;
    end else if (w_a_zero || w_b_zero) begin
      w_res = {w_sign, 31'd0};
    end
  end
`else
  assign w_res = w_mul;
`endif

  // Operands are captured on the request handshake; they only matter outside IDLE
  always_ff @(posedge clk) begin
    if (w_req_hs) begin
      r_owner <= req1_ready;
      r_a     <= req1_ready ? req1_a   : req0_a;
      r_b     <= req1_ready ? req1_b   : req0_b;
      r_tag   <= req1_ready ? req1_tag : req0_tag;
    end
  end

  // Result register loads at the end of EXEC and holds until consumed
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last      <= 1'b1;
      r_rsp_valid <= 2'b00;
      r_rsp_data  <= '0;
      r_rsp_tag   <= '0;
      r_ops_cnt   <= '0;
    end else begin
      if (w_req_hs) r_last <= req1_ready;
      if (r_state == EXEC) begin
        r_rsp_valid <= r_owner ? 2'b10 : 2'b01;
        r_rsp_data  <= w_res;
        r_rsp_tag   <= r_tag;
      end
      if (w_rsp_hs) begin
        r_rsp_valid <= 2'b00;
        r_ops_cnt   <= r_ops_cnt + 16'd1;
      end
    end
  end

  assign rsp0_valid = r_rsp_valid[0];
  assign rsp1_valid = r_rsp_valid[1];
  assign rsp0_data  = r_rsp_data;
  assign rsp1_data  = r_rsp_data;
  assign rsp0_tag   = r_rsp_tag;
  assign rsp1_tag   = r_rsp_tag;
  assign busy       = (r_state != IDLE);
  assign ops_cnt    = r_ops_cnt;

endmodule

// File: tb/tb_fpmul_arbiter.sv
// Directed self-checking bench for fpmul_arbiter: latency, arbitration,
// backpressure, reset abort, rounding corners and counter wrap.
module tb_fpmul_arbiter;

  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req0_valid, req1_valid;
  logic             req0_ready, req1_ready;
  logic [31:0]      req0_a, req0_b, req1_a, req1_b;
  logic [TAG_W-1:0] req0_tag, req1_tag;
  logic             rsp0_valid, rsp1_valid;
  logic             rsp0_ready, rsp1_ready;
  logic [31:0]      rsp0_data, rsp1_data;
  logic [TAG_W-1:0] rsp0_tag, rsp1_tag;
  logic             busy;
  logic [15:0]      ops_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  fpmul_arbiter #(.TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_tag   (req0_tag),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_tag   (req1_tag),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp0_data  (rsp0_data),
    .rsp0_tag   (rsp0_tag),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp1_data  (rsp1_data),
    .rsp1_tag   (rsp1_tag),
    .busy       (busy),
    .ops_cnt    (ops_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete operation for a single requester with its rsp_ready held high
  task automatic do_op(input int who, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] tag, input logic [31:0] exp, input string name);
    if (who == 0) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_tag = tag; rsp0_ready = 1'b1;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_tag = tag; rsp1_ready = 1'b1;
    end
    #1;
    chk({name, "_rdy"}, 32'((who == 0) ? req0_ready : req1_ready), 1);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = 32'hDEAD_BEEF; req1_a = 32'hDEAD_BEEF;
    tick();
    chk({name, "_vld"},  32'((who == 0) ? rsp0_valid : rsp1_valid), 1);
    chk({name, "_data"}, (who == 0) ? rsp0_data : rsp1_data, exp);
    chk({name, "_tag"},  32'((who == 0) ? rsp0_tag : rsp1_tag), 32'(tag));
    tick();
    chk({name, "_done"}, 32'((who == 0) ? rsp0_valid : rsp1_valid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_tag = '0;
    req1_a = '0; req1_b = '0; req1_tag = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    tick();
    tick();
    chk("rst_rdy0",  32'(req0_ready), 0);
    chk("rst_rdy1",  32'(req1_ready), 0);
    chk("rst_vld0",  32'(rsp0_valid), 0);
    chk("rst_vld1",  32'(rsp1_valid), 0);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_data",  rsp0_data, 0);
    chk("rst_tag",   32'(rsp0_tag), 0);
    chk("rst_ops",   32'(ops_cnt), 0);
    rst_n = 1'b1;

    // Single operation, exact latency
    req0_valid = 1'b1; req0_a = 32'h4000_0000; req0_b = 32'h4040_0000; req0_tag = 4'd3;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    #1;
    chk("single_rdy0", 32'(req0_ready), 1);
    chk("single_rdy1", 32'(req1_ready), 0);
    tick();
    req0_valid = 1'b0; req0_a = 32'hFFFF_FFFF; req0_b = 32'h1234_5678; req0_tag = 4'hF;
    chk("single_busy",  32'(busy), 1);
    chk("single_early", 32'(rsp0_valid), 0);
    tick();
    chk("single_vld",  32'(rsp0_valid), 1);
    chk("single_data", rsp0_data, 32'h40C0_0000);
    chk("single_tag",  32'(rsp0_tag), 3);
    chk("single_vld1", 32'(rsp1_valid), 0);
    chk("single_ops0", 32'(ops_cnt), 0);
    tick();
    chk("single_done", 32'(rsp0_valid), 0);
    chk("single_ops1", 32'(ops_cnt), 1);
    chk("single_idle", 32'(busy), 0);

    // Rounding and range corners
    do_op(0, 32'h3FC0_0000, 32'h3F80_0001, 4'd1, 32'h3FC0_0002, "tie_odd");
    do_op(1, 32'h3FC0_0000, 32'h3F80_0003, 4'd2, 32'h3FC0_0004, "tie_even");
    do_op(0, 32'h3F80_0001, 32'h3F80_0001, 4'd4, 32'h3F80_0002, "below_half");
    do_op(1, 32'h3FC0_0001, 32'h3FC0_0001, 4'd5, 32'h4010_0002, "above_half");
    do_op(0, 32'h7F00_0000, 32'h7F00_0000, 4'd6, 32'h7F80_0000, "overflow");
    do_op(1, 32'h0080_0000, 32'h0080_0000, 4'd7, 32'h0000_0000, "underflow");
    do_op(0, 32'hBF80_0000, 32'h3F80_0000, 4'd8, 32'hBF80_0000, "neg_one");

    // Contention straight after reset: requester 0 first
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst2_ops", 32'(ops_cnt), 0);
    req0_valid = 1'b1; req0_a = 32'h3FC0_0000; req0_b = 32'hC080_0000; req0_tag = 4'd1;
    req1_valid = 1'b1; req1_a = 32'h4000_0000; req1_b = 32'h4000_0000; req1_tag = 4'd2;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    #1;
    chk("cont_rdy0", 32'(req0_ready), 1);
    chk("cont_rdy1", 32'(req1_ready), 0);
    tick();
    req0_valid = 1'b0;
    #1;
    chk("cont_exec_rdy1", 32'(req1_ready), 0);
    tick();
    chk("cont_vld0",  32'(rsp0_valid), 1);
    chk("cont_data0", rsp0_data, 32'hC0C0_0000);
    chk("cont_tag0",  32'(rsp0_tag), 1);
    chk("cont_vld1a", 32'(rsp1_valid), 0);
    tick();
    chk("cont_done0", 32'(rsp0_valid), 0);
    chk("cont_rdy1b", 32'(req1_ready), 1);
    tick();
    req1_valid = 1'b0;
    tick();
    chk("cont_vld1",  32'(rsp1_valid), 1);
    chk("cont_data1", rsp1_data, 32'h4080_0000);
    chk("cont_tag1",  32'(rsp1_tag), 2);
    chk("cont_vld0b", 32'(rsp0_valid), 0);
    tick();
    chk("cont_done1", 32'(rsp1_valid), 0);
    chk("cont_ops",   32'(ops_cnt), 2);

    // Round-robin alternation, then backpressure on requester 1
    req0_valid = 1'b1; req0_a = 32'h3F80_0000; req0_b = 32'h3F80_0000; req0_tag = 4'd6;
    req1_valid = 1'b1; req1_a = 32'h4040_0000; req1_b = 32'h4040_0000; req1_tag = 4'd5;
    rsp0_ready = 1'b1; rsp1_ready = 1'b0;
    #1;
    chk("rr_rdy0", 32'(req0_ready), 1);
    chk("rr_rdy1", 32'(req1_ready), 0);
    tick();
    tick();
    chk("rr_data0", rsp0_data, 32'h3F80_0000);
    tick();
    chk("rr_rdy1b", 32'(req1_ready), 1);
    chk("rr_rdy0b", 32'(req0_ready), 0);
    tick();
    req1_valid = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("bp_vld",  32'(rsp1_valid), 1);
      chk("bp_data", rsp1_data, 32'h4110_0000);
      chk("bp_tag",  32'(rsp1_tag), 5);
      chk("bp_rdy0", 32'(req0_ready), 0);
      chk("bp_busy", 32'(busy), 1);
      chk("bp_vld0", 32'(rsp0_valid), 0);
      tick();
    end
    rsp1_ready = 1'b1;
    #1;
    chk("bp_hs_rdy0", 32'(req0_ready), 0);
    tick();
    chk("bp_done", 32'(rsp1_valid), 0);
    chk("bp_idle", 32'(busy), 0);
    chk("bp_resume_rdy0", 32'(req0_ready), 1);
    req0_valid = 1'b0;
    tick();

    // Reset in the middle of EXEC discards the operation
    req0_valid = 1'b1; req0_a = 32'h4000_0000; req0_b = 32'h4040_0000; req0_tag = 4'd7;
    rsp0_ready = 1'b1;
    tick();
    req0_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_vld",  32'(rsp0_valid), 0);
    chk("abort_ops",  32'(ops_cnt), 0);
    tick();
    tick();
    chk("abort_vld_late", 32'(rsp0_valid), 0);
    do_op(0, 32'h4000_0000, 32'h4040_0000, 4'd7, 32'h40C0_0000, "after_abort");
    chk("after_abort_ops", 32'(ops_cnt), 1);

`ifdef FPMUL_SPECIAL_EN
    do_op(0, 32'h0000_0000, 32'h7F80_0000, 4'd1, 32'h7FC0_0000, "sp_zero_inf");
    do_op(1, 32'h8000_0000, 32'h4000_0000, 4'd2, 32'h8000_0000, "sp_negzero");
    do_op(0, 32'hFF80_0000, 32'h4000_0000, 4'd3, 32'hFF80_0000, "sp_ninf");
    do_op(1, 32'h7FC0_0001, 32'h3F80_0000, 4'd4, 32'h7FC0_0000, "sp_nan");
`endif

    // Counter wrap from FFFF
    force dut.r_ops_cnt = 16'hFFFF;
    tick();
    release dut.r_ops_cnt;
    tick();
    chk("wrap_pre", 32'(ops_cnt), 32'h0000_FFFF);
    do_op(1, 32'h4000_0000, 32'h3F80_0000, 4'd9, 32'h4000_0000, "wrap_op");
    chk("wrap_ops", 32'(ops_cnt), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
